mem_access_ctrl: RTL

//  Data-memory access controller between the EX/MEM pipeline register and the mem stage. Runs each load/store
//  on an external req/gnt/rvalid data bus, steers store byte lanes, and aligns and sign-extends load data.
//  Its result drives the mem stage's mem_r_data_i. Stalls the pipeline while a transaction is outstanding.

---
 rtl/mem_access_ctrl_pkg.sv | 39 +++
 rtl/mem_access_ctrl_lsu_align.sv | 82 ++++++++
 rtl/mem_access_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Holds the controller state encoding, the funct3 access-width codes,
// the byte-enable width and a helper that builds lane enables from an
// access size and the low address bits.
package mem_access_ctrl_pkg;

  localparam int BE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } lsu_state_e;

  // funct3 codes; stores share the low three with loads (SB/SH/SW)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] gives the access size
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic [BE_W-1:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [BE_W-1:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lsu_align.sv
// Combinational lane logic for the access controller.
// Request side: legality/alignment check, byte enables and lane-replicated
// store data for the op on the inputs. Response side: picks the byte or
// half out of the returned word and sign/zero-extends it.
// Ports:
//   is_load_i   - request is a load (affects which funct3 codes are legal)
//   funct3_i    - request width/sign code
//   addr_lo_i   - request byte offset within the word
//   st_data_i   - raw store data
//   ld_funct3_i - width/sign of the load in flight
//   ld_off_i    - byte offset of the load in flight
//   rdata_i     - word returned by the bus
//   legal_o     - funct3 is a valid code for this direction
//   aligned_o   - offset is naturally aligned for the size
//   be_o        - byte enables
//   st_wdata_o  - store data replicated across lanes
//   ld_data_o   - aligned, extended load result
module mem_access_ctrl_lsu_align
  import mem_access_ctrl_pkg::*;
(
  input  logic            is_load_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [31:0]     st_data_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_off_i,
  input  logic [31:0]     rdata_i,
  output logic            legal_o,
  output logic            aligned_o,
  output logic [BE_W-1:0] be_o,
  output logic [31:0]     st_wdata_o,
  output logic [31:0]     ld_data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // request legality, alignment, lane enables and store data
  always_comb begin
    legal_o    = 1'b0;
    aligned_o  = 1'b0;
    be_o       = lane_be(funct3_i[1:0], addr_lo_i);
    st_wdata_o = st_data_i;
    case (funct3_i)
      F3_B, F3_H, F3_W: legal_o = 1'b1;
      F3_BU, F3_HU:     legal_o = is_load_i;
      default:          legal_o = 1'b0;
    endcase
    case (funct3_i[1:0])
      SZ_B:    aligned_o = 1'b1;
      SZ_H:    aligned_o = ~addr_lo_i[0];
      SZ_W:    aligned_o = (addr_lo_i == 2'b00);
      default: aligned_o = 1'b0;
    endcase
    case (funct3_i[1:0])
      SZ_B:    st_wdata_o = {4{st_data_i[7:0]}};
      SZ_H:    st_wdata_o = {2{st_data_i[15:0]}};
      default: st_wdata_o = st_data_i;
    endcase
  end

  // load extraction and extension
  always_comb begin
    byte_s    = rdata_i[7:0];
    half_s    = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ld_data_o = rdata_i;
    case (ld_off_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{byte_s[7]}}, byte_s};
      F3_H:    ld_data_o = {{16{half_s[15]}}, half_s};
      F3_BU:   ld_data_o = {24'd0, byte_s};
      F3_HU:   ld_data_o = {16'd0, half_s};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller between EX/MEM and the mem stage.
// Runs one load/store at a time on a req/gnt/rvalid bus, stalls the
// pipeline while it is outstanding and returns aligned load data.
// Ports:
//   clk, arst_n            - clock, synchronous active-low reset
//   mem_r_ena_i/_addr_i    - load request and byte address
//   mem_w_ena_i/_addr_i    - store request and byte address
//   mem_w_data_i, funct3_i - store data, access width/sign
//   flush_i, pipe_hold_i   - abort current op, hold result in DONE
//   dbus_*_o               - registered bus request signals
//   dbus_gnt_i/_rvalid_i/_rdata_i - bus responses
//   mem_r_data_o           - load result (held until next load)
//   stall_req_o            - freeze upstream pipeline
//   misalign_o, bus_err_o  - single-cycle error pulses
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            mem_r_ena_i,
  input  logic [31:0]     mem_r_addr_i,
  input  logic            mem_w_ena_i,
  input  logic [31:0]     mem_w_addr_i,
  input  logic [31:0]     mem_w_data_i,
  input  logic [2:0]      funct3_i,
  input  logic            flush_i,
  input  logic            pipe_hold_i,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [31:0]     dbus_addr_o,
  output logic [BE_W-1:0] dbus_be_o,
  output logic [31:0]     dbus_wdata_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [31:0]     dbus_rdata_i,
  output logic [31:0]     mem_r_data_o,
  output logic            stall_req_o,
  output logic            misalign_o,
  output logic            bus_err_o
);

  // one spare bit so a flush on the last WAIT cycle can still count into DRAIN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       ld_f3_q;
  logic [1:0]       ld_off_q;
  logic             req_q, we_q, misalign_q, bus_err_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [BE_W-1:0]  be_q;

  logic             op_new_s, is_load_s, legal_s, aligned_s, accept_s, bad_s;
  logic [31:0]      addr_s, st_wdata_s, ld_data_s;
  logic [BE_W-1:0]  be_s;

  // a simultaneous load and store: the load wins
  assign op_new_s  = mem_r_ena_i | mem_w_ena_i;
  assign is_load_s = mem_r_ena_i;
  assign addr_s    = is_load_s ? mem_r_addr_i : mem_w_addr_i;

  mem_access_ctrl_lsu_align u_align (
    .is_load_i   (is_load_s),
    .funct3_i    (funct3_i),
    .addr_lo_i   (addr_s[1:0]),
    .st_data_i   (mem_w_data_i),
    .ld_funct3_i (ld_f3_q),
    .ld_off_i    (ld_off_q),
    .rdata_i     (dbus_rdata_i),
    .legal_o     (legal_s),
    .aligned_o   (aligned_s),
    .be_o        (be_s),
    .st_wdata_o  (st_wdata_s),
    .ld_data_o   (ld_data_s)
  );

  assign accept_s = (state_q == ST_IDLE) & op_new_s & ~flush_i & legal_s & aligned_s;
  assign bad_s    = (state_q == ST_IDLE) & op_new_s & ~(legal_s & aligned_s);

  // stall starts in the same cycle an op is accepted, before the FSM registers it
  assign stall_req_o  = accept_s | (state_q == ST_REQ) | (state_q == ST_WAIT) | (state_q == ST_DRAIN);
  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;
  assign mem_r_data_o = rdata_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

  // controller FSM, timeout counter and all registered outputs
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ld_f3_q    <= 3'd0;
      ld_off_q   <= 2'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            req_q    <= 1'b1;
            we_q     <= ~is_load_s;
            addr_q   <= {addr_s[31:2], 2'b00};
            be_q     <= be_s;
            wdata_q  <= is_load_s ? 32'd0 : st_wdata_s;
            ld_f3_q  <= funct3_i;
            ld_off_q <= addr_s[1:0];
            state_q  <= ST_REQ;
          end else if (bad_s) begin
            misalign_q <= 1'b1;
          end
        end
        ST_REQ: begin
          // bus outputs drop to zero whenever REQ is left
          if (flush_i || dbus_gnt_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            cnt_q   <= '0;
          end
          if (flush_i) begin
            // a granted load still owes an rvalid, so soak it up in DRAIN
            state_q <= (dbus_gnt_i && !we_q) ? ST_DRAIN : ST_IDLE;
          end else if (dbus_gnt_i) begin
            state_q <= we_q ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dbus_rvalid_i) begin
            if (flush_i) begin
              state_q <= ST_IDLE;
            end else begin
              rdata_q <= ld_data_s;
              state_q <= ST_DONE;
            end
          end else if (flush_i) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= ST_DRAIN;
          end else if (cnt_q == CNT_LAST) begin
            bus_err_q <= 1'b1;
            rdata_q   <= 32'd0;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (dbus_rvalid_i) begin
            state_q <= ST_IDLE;
          end else if (cnt_q >= CNT_LAST) begin
            bus_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (!pipe_hold_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
